registro_ctrl: RTL

- Command sequencer for the parameterised universal shift register (`registro`) in the shift-register datapath.
- Accepts one command at a time over a valid/ready handshake.
- Drives the register's D, MODO, DIR, S_IN and ENB for one LOAD cycle and/or N shift cycles (PUSH or CYCLE), then pulses DONE.
- Supports stall and abort; exposes busy status and remaining-shift count.

---
 rtl/registro_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/registro_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : registro_ctrl
//  Purpose  : Command sequencer for the universal shift register (registro).
//             Accepts one command at a time over a valid/ready handshake,
//             issues an optional LOAD cycle followed by N PUSH or CYCLE
//             shift cycles, then pulses DONE for one cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK        in   1      clock, rising edge
//    RESET_L    in   1      synchronous reset, active low
//    CMD_VALID  in   1      command present
//    CMD_READY  out  1      controller can accept a command (IDLE only)
//    CMD_OP     in   2      00 load; 01 load+PUSH; 10 load+CYCLE; 11 CYCLE only
//    CMD_DIR    in   1      shift direction (0 left, 1 right)
//    CMD_FILL   in   1      serial-in bit used during PUSH
//    CMD_COUNT  in   CW     number of enabled shift cycles
//    CMD_DATA   in   WIDTH  parallel load word
//    STALL      in   1      freeze sequencing this cycle
//    ABORT      in   1      cancel the active command
//    REG_D      out  WIDTH  to registro D
//    REG_MODO   out  2      to registro MODO
//    REG_DIR    out  1      to registro DIR
//    REG_S_IN   out  1      to registro S_IN
//    REG_ENB    out  1      to registro ENB
//    BUSY       out  1      high in any state other than IDLE
//    DONE       out  1      one-cycle completion pulse
//    REMAIN     out  CW     shift cycles still to issue
// ============================================================================
module registro_ctrl #(
  parameter int         WIDTH      = 32,
  parameter int         CW         = $clog2(WIDTH) + 1,
  // MODO encodings; must match the values used by the attached registro.
  parameter logic [1:0] MODE_PUSH  = 2'b00,
  parameter logic [1:0] MODE_CYCLE = 2'b01,
  parameter logic [1:0] MODE_LOAD  = 2'b10
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic             CMD_DIR,
  input  logic             CMD_FILL,
  input  logic [CW-1:0]    CMD_COUNT,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic             STALL,
  input  logic             ABORT,
  output logic [WIDTH-1:0] REG_D,
  output logic [1:0]       REG_MODO,
  output logic             REG_DIR,
  output logic             REG_S_IN,
  output logic             REG_ENB,
  output logic             BUSY,
  output logic             DONE,
  output logic [CW-1:0]    REMAIN
);

  localparam logic [1:0] OP_LOAD_ONLY  = 2'b00;
  localparam logic [1:0] OP_LOAD_PUSH  = 2'b01;
  localparam logic [1:0] OP_LOAD_CYCLE = 2'b10;
  localparam logic [1:0] OP_CYCLE_ONLY = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data_lat;
  logic             dir_lat;
  logic             fill_lat;
  logic [1:0]       op_lat;
  logic [CW-1:0]    remain;

  logic             active;
  logic             has_shift_op;

  assign active       = (state == ST_LOAD) || (state == ST_SHIFT);
  assign has_shift_op = (op_lat == OP_LOAD_PUSH) || (op_lat == OP_LOAD_CYCLE);

  // --------------------------------------------------------------------------
  // Sequencer: state, latched command fields and remaining-shift counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state    <= ST_IDLE;
      data_lat <= '0;
      dir_lat  <= 1'b0;
      fill_lat <= 1'b0;
      op_lat   <= OP_LOAD_ONLY;
      remain   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CMD_VALID && CMD_READY) begin
            data_lat <= CMD_DATA;
            dir_lat  <= CMD_DIR;
            // The fill bit only matters for PUSH; storing 0 otherwise keeps
            // S_IN quiet for rotate and load-only commands.
            fill_lat <= CMD_FILL && (CMD_OP == OP_LOAD_PUSH);
            op_lat   <= CMD_OP;
            remain   <= CMD_COUNT;
            if (CMD_OP != OP_CYCLE_ONLY) begin
              state <= ST_LOAD;
            end else if (CMD_COUNT != '0) begin
              state <= ST_SHIFT;
            end else begin
              state <= ST_DONE;
            end
          end
        end

        ST_LOAD: begin
          if (ABORT) begin
            state  <= ST_IDLE;
            remain <= '0;
          end else if (!STALL) begin
            if (has_shift_op && (remain != '0)) begin
              state <= ST_SHIFT;
            end else begin
              // Load-only commands never issue shifts, so nothing remains.
              state  <= ST_DONE;
              remain <= '0;
            end
          end
        end

        ST_SHIFT: begin
          if (ABORT) begin
            state  <= ST_IDLE;
            remain <= '0;
          end else if (!STALL) begin
            // <= 1 rather than == 1 so a zero count can never underflow.
            if (remain <= CW'(1)) begin
              state  <= ST_DONE;
              remain <= '0;
            end else begin
              remain <= remain - CW'(1);
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs decoded from state and latched fields.
  // --------------------------------------------------------------------------
  always_comb begin
    REG_MODO = MODE_LOAD;
    if (state == ST_SHIFT) begin
      REG_MODO = (op_lat == OP_LOAD_PUSH) ? MODE_PUSH : MODE_CYCLE;
    end
  end

  // ABORT also masks the enable of the cycle in which it is raised so the
  // register stops at exactly the number of shifts already completed.
  assign REG_ENB   = active && !STALL && !ABORT;
  assign REG_D     = data_lat;
  assign REG_DIR   = dir_lat;
  assign REG_S_IN  = fill_lat;
  assign CMD_READY = RESET_L && (state == ST_IDLE);
  assign BUSY      = (state != ST_IDLE);
  assign DONE      = (state == ST_DONE);
  assign REMAIN    = remain;

endmodule
`default_nettype wire
